// File: rtl/uart_pkg.sv
// Shared constants and state encoding for the UART link (receive and transmit sides).
package uart_pkg;

   localparam int UART_DATA_BITS            = 8;
   localparam int UART_DEFAULT_CLKS_PER_BIT = 434;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } uart_state_e;

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for the asynchronous serial line plus falling-edge detect.
module uart_rx_sync (
   input  logic clk,
   input  logic reset,
   input  logic serial,
   output logic level,
   output logic fall
);

   logic meta;
   logic sync;
   logic prev;

   // All flops reset to the idle-high line level so reset never fakes a start edge.
   always_ff @(posedge clk) begin
      if (reset) begin
         meta <= 1'b1;
         sync <= 1'b1;
         prev <= 1'b1;
      end else begin
         meta <= serial;
         sync <= meta;
         prev <= sync;
      end
   end

   assign level = sync;
   assign fall  = ~sync & prev;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver with a one-entry valid/ready holding register, framing-error and overrun pulses.
module uart_rx
   import uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = UART_DEFAULT_CLKS_PER_BIT
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       serial,
   input  logic       rx_ready,
   output logic [7:0] rx_data,
   output logic       rx_valid,
   output logic       frame_err,
   output logic       overrun,
   output logic       busy
);

   localparam int CW = $clog2(CLKS_PER_BIT);
   localparam int BW = $clog2(UART_DATA_BITS);
   localparam logic [CW-1:0] CNT_LAST  = CW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
   localparam logic [BW-1:0] BIT_LAST  = BW'(UART_DATA_BITS - 1);

   logic                      level;
   logic                      fall;
   uart_state_e               state;
   logic [CW-1:0]             cnt;
   logic [BW-1:0]             bit_idx;
   logic [UART_DATA_BITS-1:0] shreg;

   uart_rx_sync u_sync (
      .clk    (clk),
      .reset  (reset),
      .serial (serial),
      .level  (level),
      .fall   (fall)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         cnt       <= '0;
         bit_idx   <= '0;
         shreg     <= '0;
         rx_data   <= 8'h00;
         rx_valid  <= 1'b0;
         frame_err <= 1'b0;
         overrun   <= 1'b0;
      end else begin
         frame_err <= 1'b0;
         overrun   <= 1'b0;
         // Consumption first; a delivery later in this block overrides the clear.
         if (rx_valid && rx_ready)
            rx_valid <= 1'b0;

         case (state)
            IDLE: begin
               if (fall) begin
                  state <= START;
                  cnt   <= '0;
               end
            end
            START: begin
               if (cnt == HALF_LAST) begin
                  cnt     <= '0;
                  bit_idx <= '0;
                  state   <= level ? IDLE : DATA;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            DATA: begin
               if (cnt == CNT_LAST) begin
                  cnt   <= '0;
                  shreg <= {level, shreg[UART_DATA_BITS-1:1]};
                  if (bit_idx == BIT_LAST)
                     state <= STOP;
                  else
                     bit_idx <= bit_idx + 1'b1;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            STOP: begin
               if (cnt == CNT_LAST) begin
                  cnt   <= '0;
                  state <= IDLE;
                  if (!level) begin
                     frame_err <= 1'b1;
                  end else if (!rx_valid || rx_ready) begin
                     rx_data  <= shreg;
                     rx_valid <= 1'b1;
                  end else begin
                     overrun <= 1'b1;
                  end
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign busy = (state != IDLE);

endmodule

// File: doc/uart_rx.md
# uart_rx

Serial receiver for the data-memory UART link. It consumes the `serial` line driven by the memory-mapped UART transmit register and deframes 8N1 characters (1 start, 8 data LSB-first, 1 stop, no parity). Each received byte is presented on a one-entry valid/ready holding register, with framing-error and overrun flags. It is the receive side of the link, used by a peer core and by the system bench to check transmitted bytes.

## Interface
Parameters:
- `CLKS_PER_BIT`, 434, clock cycles per bit (50 MHz / 115200). Must be ≥ 4; N below.

Ports:
- `clk`  in  1  system clock, rising edge.
- `reset`  in  1  synchronous, active-high; one clock domain only.
- `serial`  in  1  asynchronous line, idle high.
- `rx_ready`  in  1  consumer accepts `rx_data` this cycle.
- `rx_data`  out  8  received byte; stable while `rx_valid`.
- `rx_valid`  out  1  holding register full.
- `frame_err`  out  1  one-cycle pulse: stop bit sampled low.
- `overrun`  out  1  one-cycle pulse: byte completed while holding register full and not consumed.
- `busy`  out  1  high in any state except IDLE.

## Operation
- Input path: 2-flop synchronizer on `serial` (reset value 1), plus a registered previous sample. Falling edge = sync==0 && prev==1.
- Counter width is $clog2(N). H = floor(N/2).
- States:
  - IDLE: on falling edge → START, count cleared.
  - START: after H cycles, sample the line. Low → DATA (bit index 0). High → IDLE (glitch, no flags).
  - DATA: sample every N cycles into a shift register, LSB first. After the 8th sample → STOP.
  - STOP: sample N cycles after bit 7, then → IDLE.
    - High: deliver the byte.
    - Low: pulse `frame_err` and discard the byte.
- IDLE re-arms only on a new falling edge. A line held low after a framing error does not restart reception.
- Delivery to the holding register:
  - If `rx_valid`==0, or `rx_ready`==1 in the same cycle: load `rx_data` and set `rx_valid`.
  - Otherwise: keep the old byte, drop the new one, pulse `overrun`.
- Consumption: `rx_valid && rx_ready` clears `rx_valid`, unless a delivery occurs in the same cycle (load wins).
- Reset, including mid-frame: state IDLE, counters 0, `rx_data`=0x00, `rx_valid`=0, `frame_err`=0, `overrun`=0, `busy`=0, synchronizer flops = 1.

## Timing
- Let cycle e be the cycle the falling edge is detected (2 cycles after the pin falls).
  - Start sample: e+H.
  - Data bit i sample: e+H+N·(i+1), for i = 0..7.
  - Stop sample: e+H+9N.
- `rx_valid` (or `frame_err` / `overrun`) asserts registered at e+H+9N+1.
- `busy` rises at e+1 and falls at e+H+9N+1.
- Back-to-back frames: a new start edge is detectable from cycle e+H+9N+1 onward. No extra idle bit is required.
- `frame_err` and `overrun` are exactly 1 cycle wide. They are mutually exclusive per frame.

## Structure
- Package `uart_pkg`:
  - state enum (IDLE, START, DATA, STOP);
  - `UART_DATA_BITS`=8;
  - `UART_DEFAULT_CLKS_PER_BIT`=434.
  - The transmit register imports the same constants.
- Sub-module `uart_rx_sync`: 2-flop synchronizer plus falling-edge detect. Outputs the synchronized level and an edge pulse.
- Top level: FSM, bit counter, shift register, holding register.

## Test plan
All scenarios use N=8, H=4.
- Frame 0xA5, `rx_ready`=0 → `rx_valid`=1 at e+77 with `rx_data`=0xA5, held until `rx_ready` pulses, then `rx_valid`=0 next cycle.
- Line pulled low for 2 cycles then high → START aborts at e+4. No `rx_valid`, no flags; `busy` returns to 0.
- Frame 0x3C with stop bit low → `frame_err` pulses at e+77. `rx_valid` stays 0; holding register unchanged.
- Frames 0x11 then 0x22 back-to-back, `rx_ready`=0 → `overrun` pulses at the 2nd delivery; `rx_data` stays 0x11.
- As the previous scenario, but with `rx_ready`=1 exactly at the 2nd delivery cycle → no `overrun`; `rx_data`=0x22 and `rx_valid` stays 1.
- `reset` asserted at mid-bit 3 of frame 0xFF → all outputs return to reset values next cycle. A following frame 0x5A is received correctly.
